// File: rtl/tri_edge_raster.sv
// tri_edge_raster: gathers vertex triples and walks each triangle edge with Bresenham, emitting framebuffer addresses.
// Optional macro BACKFACE_CULL_EN adds a one-cycle winding test that drops triangles with negative area.
module tri_edge_raster #(
  parameter int WIDTH  = 360,
  parameter int HEIGHT = 360,
  parameter int ADDR_W = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [2:0][8:0]   coor_in,
  input  logic              valid_in,
  input  logic              obj_done_in,
  output logic              ready_out,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              pixel_valid_out,
  input  logic              pixel_ready_in,
  output logic              tri_done_out,
  output logic              obj_done_out
);
`ifdef BACKFACE_CULL_EN
  typedef enum logic [2:0] {V0, V1, V2, CULL, SETUP, DRAW, DONE} state_t;
`else
  typedef enum logic [2:0] {V0, V1, V2, SETUP, DRAW, DONE} state_t;
`endif
  state_t state, state_n;
  logic [8:0] vx [3];
  logic [8:0] vy [3];
  logic [1:0] eidx, slot, s_idx, e_idx;
  logic acc, accept, on, adv, at_end, step_x, step_y, sx, sy;
  logic [8:0] cx, cy, ex, ey, nx, ny, x0, y0, x1, y1, adx, ady;
  logic [9:0] dx;
  logic signed [10:0] dy;
  logic signed [11:0] err, err_n;
  logic signed [12:0] e2;
  logic unused_z;
  assign unused_z = ^coor_in[0];
`ifdef BACKFACE_CULL_EN
  logic signed [9:0] ax1, ay1, ax2, ay2;
  logic signed [20:0] area;
  always_comb begin
    ax1 = 10'(vx[1]) - 10'(vx[0]);
    ay1 = 10'(vy[1]) - 10'(vy[0]);
    ax2 = 10'(vx[2]) - 10'(vx[0]);
    ay2 = 10'(vy[2]) - 10'(vy[0]);
    area = 21'(ax1) * 21'(ay2) - 21'(ax2) * 21'(ay1);
  end
`endif
  assign tri_done_out = state == DONE;
  assign obj_done_out = state == DONE && acc;
  assign pixel_valid_out = on;
  always_comb begin
    accept = valid_in && ready_out;
    slot = state == V1 ? 2'd1 : state == V2 ? 2'd2 : 2'd0;
    s_idx = eidx;
    e_idx = eidx == 2'd2 ? 2'd0 : eidx + 2'd1;
    x0 = vx[s_idx];
    y0 = vy[s_idx];
    x1 = vx[e_idx];
    y1 = vy[e_idx];
    adx = x1 >= x0 ? x1 - x0 : x0 - x1;
    ady = y1 >= y0 ? y1 - y0 : y0 - y1;
    on = state == DRAW && 32'(cx) < WIDTH && 32'(cy) < HEIGHT;
    // off-screen points never wait for the framebuffer
    adv = !on || pixel_ready_in;
    at_end = cx == ex && cy == ey;
    e2 = {err, 1'b0};
    step_x = e2 >= $signed({{2{dy[10]}}, dy});
    step_y = e2 <= $signed({3'b0, dx});
    state_n = state;
    nx = cx;
    ny = cy;
    err_n = err;
    case (state)
      V0: state_n = accept ? V1 : V0;
      V1: state_n = accept ? V2 : V1;
`ifdef BACKFACE_CULL_EN
      V2: state_n = accept ? CULL : V2;
      CULL: state_n = area[20] ? DONE : SETUP;
`else
      V2: state_n = accept ? SETUP : V2;
`endif
      SETUP: begin
        state_n = DRAW;
        nx = x0;
        ny = y0;
        err_n = $signed({3'b0, adx}) - $signed({3'b0, ady});
      end
      DRAW: if (adv) begin
        if (at_end) state_n = eidx == 2'd2 ? DONE : SETUP;
        else begin
          nx = step_x ? (sx ? cx - 9'd1 : cx + 9'd1) : cx;
          ny = step_y ? (sy ? cy - 9'd1 : cy + 9'd1) : cy;
          err_n = err + (step_x ? $signed({dy[10], dy}) : 12'sd0) + (step_y ? $signed({2'b0, dx}) : 12'sd0);
        end
      end
      DONE: state_n = V0;
      default: state_n = V0;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state <= V0;
      ready_out <= 1'b0;
      acc <= 1'b0;
      eidx <= '0;
      cx <= '0;
      cy <= '0;
      err <= '0;
      pixel_addr <= '0;
    end else begin
      state <= state_n;
      ready_out <= state_n inside {V0, V1, V2};
      acc <= state == DONE ? 1'b0 : acc | (accept & obj_done_in);
      cx <= nx;
      cy <= ny;
      err <= err_n;
      pixel_addr <= ADDR_W'(32'(ny) * 32'(WIDTH) + 32'(nx));
      if (accept) begin
        vx[slot] <= coor_in[2];
        vy[slot] <= coor_in[1];
      end
      if (state == SETUP) begin
        dx <= {1'b0, adx};
        dy <= 11'd0 - {2'b0, ady};
        sx <= x1 < x0;
        sy <= y1 < y0;
        ex <= x1;
        ey <= y1;
      end
      if (state == DRAW && adv && at_end) eidx <= eidx + 2'd1;
      if (state == DONE) eidx <= '0;
    end
  end
endmodule

// File: tb/tb_tri_edge_raster.sv
// tb_tri_edge_raster: scoreboard bench; expected pixels come from a plain integer line-walk model per triangle.
module tb_tri_edge_raster;
  logic clk_in = 0;
  logic rst_in = 0;
  logic [2:0][8:0] coor_in = '0;
  logic valid_in = 0, obj_done_in = 0, pixel_ready_in = 1;
  logic ready_out, pixel_valid_out, tri_done_out, obj_done_out;
  logic [16:0] pixel_addr;
  int exp_q[$], done_q[$], got_q[$];
  int tests = 0, fails = 0, n_done = 0, cyc = 0, last_pix_cyc = 0, done_cyc = 0, bp_mode = 0;
  bit rdy_chk = 0;
  int ref_l[12] = '{0, 1, 2, 3, 3, 362, 721, 1080, 1080, 720, 360, 0};

  tri_edge_raster dut (
    .clk_in(clk_in), .rst_in(rst_in), .coor_in(coor_in), .valid_in(valid_in),
    .obj_done_in(obj_done_in), .ready_out(ready_out), .pixel_addr(pixel_addr),
    .pixel_valid_out(pixel_valid_out), .pixel_ready_in(pixel_ready_in),
    .tri_done_out(tri_done_out), .obj_done_out(obj_done_out)
  );

  initial forever #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc++;

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, want, $time);
    end
  endtask

  task automatic model_edge(input int ax, input int ay, input int bx, input int by);
    int dx, dy, sx, sy, err, x, y, e2;
    dx = ax > bx ? ax - bx : bx - ax;
    dy = ay > by ? by - ay : ay - by;
    sx = ax < bx ? 1 : -1;
    sy = ay < by ? 1 : -1;
    err = dx + dy;
    x = ax;
    y = ay;
    forever begin
      if (x < 360 && y < 360) exp_q.push_back(y * 360 + x);
      if (x == bx && y == by) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  task automatic send_tri(input int x0, input int y0, input int x1, input int y1,
                          input int x2, input int y2, input int od);
    int xs[3], ys[3], k;
    bit draw;
    xs = '{x0, x1, x2};
    ys = '{y0, y1, y2};
    draw = 1;
`ifdef BACKFACE_CULL_EN
    draw = (x1 - x0) * (y2 - y0) - (x2 - x0) * (y1 - y0) >= 0;
`endif
    if (draw) for (int i = 0; i < 3; i++) model_edge(xs[i], ys[i], xs[(i + 1) % 3], ys[(i + 1) % 3]);
    done_q.push_back(od != 0 ? 1 : 0);
    for (int i = 0; i < 3; i++) begin
      k = 0;
      while (!ready_out && k < 5000) begin @(posedge clk_in); #1; k++; end
      chk("ready_wait", int'(ready_out), 1);
      coor_in[2] = 9'(xs[i]);
      coor_in[1] = 9'(ys[i]);
      coor_in[0] = 9'($urandom);
      obj_done_in = od[i];
      valid_in = 1;
      @(posedge clk_in); #1;
      valid_in = 0;
      obj_done_in = 0;
    end
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (n_done < target && k < 5000) begin @(posedge clk_in); #1; k++; end
    chk("tri_done_wait", n_done, target);
  endtask

  task automatic cmp_list(input string nm);
    chk({nm, "_count"}, got_q.size(), 12);
    for (int i = 0; i < 12 && i < got_q.size(); i++) chk(nm, got_q[i], ref_l[i]);
  endtask

  initial forever begin
    @(posedge clk_in); #1;
    if (bp_mode == 0) pixel_ready_in = 1;
    else if (bp_mode == 1) pixel_ready_in = $urandom_range(0, 3) != 0;
  end

  // monitor: pops the scoreboard whenever a pixel or a triangle completion is presented
  initial forever begin
    @(negedge clk_in);
    if (rst_in) begin
      if (rdy_chk) begin chk("ready_after_done", int'(ready_out), 1); rdy_chk = 0; end
      if (pixel_valid_out && pixel_ready_in) begin
        got_q.push_back(int'(pixel_addr));
        last_pix_cyc = cyc;
        if (exp_q.size() == 0) chk("extra_pixel", int'(pixel_addr), -1);
        else chk("pixel_addr", int'(pixel_addr), exp_q.pop_front());
      end
      if (tri_done_out) begin
        if (done_q.size() == 0) chk("extra_tri_done", 1, 0);
        else chk("obj_done", int'(obj_done_out), done_q.pop_front());
        chk("pixels_left_at_done", exp_q.size(), 0);
        chk("ready_in_done", int'(ready_out), 0);
        rdy_chk = 1;
        done_cyc = cyc;
        n_done++;
      end
    end else rdy_chk = 0;
  end

  initial begin
    int k, base;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_ready", int'(ready_out), 0);
    chk("rst_pvalid", int'(pixel_valid_out), 0);
    chk("rst_addr", int'(pixel_addr), 0);
    chk("rst_tri_done", int'(tri_done_out), 0);
    chk("rst_obj_done", int'(obj_done_out), 0);
    @(posedge clk_in); #1;
    rst_in = 1;
    @(posedge clk_in); #1;
    chk("ready_after_rst", int'(ready_out), 1);

    got_q.delete();
    send_tri(0, 0, 3, 0, 0, 3, 0);
    chk("ready_low_after_v2", int'(ready_out), 0);
    @(negedge clk_in);
    chk("lat_setup_pvalid", int'(pixel_valid_out), 0);
`ifdef BACKFACE_CULL_EN
    @(negedge clk_in);
    chk("lat_cull_pvalid", int'(pixel_valid_out), 0);
`endif
    @(negedge clk_in);
    chk("lat_first_pvalid", int'(pixel_valid_out), 1);
    chk("lat_first_addr", int'(pixel_addr), 0);
    wait_done(1);
    cmp_list("tri1_seq");
    chk("done_gap", done_cyc - last_pix_cyc, 1);

    got_q.delete();
    bp_mode = 2;
    pixel_ready_in = 1;
    send_tri(0, 0, 3, 0, 0, 3, 0);
    k = 0;
    while (!(pixel_valid_out && pixel_addr == 17'd362) && k < 100) begin @(posedge clk_in); #1; k++; end
    pixel_ready_in = 0;
    chk("stall_seen", int'(pixel_addr), 362);
    repeat (5) begin
      @(negedge clk_in);
      chk("stall_addr", int'(pixel_addr), 362);
      chk("stall_valid", int'(pixel_valid_out), 1);
    end
    @(posedge clk_in); #1;
    bp_mode = 0;
    pixel_ready_in = 1;
    wait_done(2);
    cmp_list("stall_seq");

    got_q.delete();
    send_tri(350, 0, 370, 0, 350, 0, 0);
    wait_done(3);
    chk("clip_count", got_q.size(), 21);

    got_q.delete();
    send_tri(5, 5, 5, 5, 5, 5, 4);
    chk("degen_ready_low", int'(ready_out), 0);
    wait_done(4);
    chk("degen_count", got_q.size(), 3);

    send_tri(0, 0, 3, 0, 0, 3, 1);
    k = 0;
    while (!(pixel_valid_out && pixel_addr == 17'd362) && k < 100) begin @(posedge clk_in); #1; k++; end
    chk("mid_e1_seen", int'(pixel_addr), 362);
    rst_in = 0;
    exp_q.delete();
    done_q.delete();
    @(posedge clk_in); #1;
    rst_in = 1;
    @(negedge clk_in);
    chk("midrst_pvalid", int'(pixel_valid_out), 0);
    chk("midrst_ready", int'(ready_out), 0);
    chk("midrst_tri_done", int'(tri_done_out), 0);
    @(negedge clk_in);
    chk("midrst_ready_back", int'(ready_out), 1);
    @(posedge clk_in); #1;
    got_q.delete();
    base = n_done;
    send_tri(0, 0, 3, 0, 0, 3, 0);
    wait_done(base + 1);
    cmp_list("post_rst_seq");

    got_q.delete();
    send_tri(0, 0, 0, 3, 3, 0, 0);
    wait_done(base + 2);
`ifdef BACKFACE_CULL_EN
    chk("cull_count", got_q.size(), 0);
`else
    chk("cw_count", got_q.size(), 12);
`endif

    bp_mode = 1;
    for (int t = 0; t < 15; t++) begin
      send_tri($urandom_range(0, 400), $urandom_range(0, 400), $urandom_range(0, 400),
               $urandom_range(0, 400), $urandom_range(0, 400), $urandom_range(0, 400),
               $urandom_range(0, 1) != 0 ? int'($urandom_range(0, 7)) : 0);
      wait_done(base + 3 + t);
    end
    bp_mode = 0;
    repeat (3) @(posedge clk_in);
    chk("final_exp_empty", exp_q.size(), 0);
    chk("final_done_empty", done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tri_edge_raster.md
Name: tri_edge_raster

Overview:
- Consumer of projected screen-space vertices from the projection stage; the receiving end of that stage's coor_out / valid / ready / obj_done interface.
- Collects three vertices into a triangle and walks its three edges with Bresenham line stepping.
- Emits one framebuffer pixel address per cycle to the framebuffer writer, which can apply backpressure.
- Sits between projection and framebuffer in the wireframe render path.

Parameters:
- WIDTH, 360, screen width in pixels; pixels with x >= WIDTH are suppressed.
- HEIGHT, 360, screen height in pixels; pixels with y >= HEIGHT are suppressed.
- ADDR_W, 17, pixel_addr width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, synchronous, active-low
- coor_in  input  9 x [2:0]  vertex; [2]=x, [1]=y, [0]=z, all unsigned; z is ignored
- valid_in  input  1  one-cycle vertex strobe from the projection stage
- obj_done_in  input  1  last-vertex-of-object flag, sampled with valid_in
- ready_out  output  1  high = the next valid_in will be captured
- pixel_addr  output  ADDR_W  y*WIDTH + x
- pixel_valid_out  output  1  pixel_addr is valid
- pixel_ready_in  input  1  framebuffer accepts the pixel
- tri_done_out  output  1  one-cycle pulse: triangle fully emitted
- obj_done_out  output  1  OR of the triangle's three obj_done flags; valid only with tri_done_out

Behaviour:
- Reset (rst_in=0 at clk edge):
  - state goes to V0.
  - ready_out=0, pixel_valid_out=0, pixel_addr=0, tri_done_out=0, obj_done_out=0.
  - Any partial triangle or in-flight edge is discarded.
  - ready_out=1 on the first cycle after reset release.
- States: V0, V1, V2, SETUP, DRAW, DONE.
- Vertex collection (V0, V1, V2):
  - ready_out=1 only in V0, V1, V2.
  - On valid_in, latch x/y into the vertex slot, OR obj_done_in into the done accumulator, and advance one state.
  - valid_in outside V0/V1/V2 is ignored; upstream only sends while ready is high.
  - V2 + valid_in goes to SETUP, and ready_out=0 from the next cycle.
- SETUP (1 cycle per edge):
  - Load the edge endpoints; edge order is e0: v0->v1, e1: v1->v2, e2: v2->v0.
  - Compute dx=|x1-x0| (10b), dy=-|y1-y0| (11b signed), sx/sy = +/-1, err=dx+dy (12b signed).
  - Current point := start vertex; go to DRAW.
- DRAW:
  - pixel_addr = cy*WIDTH + cx, registered; pixel_valid_out is high while the current point is on-screen.
  - The point advances only on (pixel_valid_out && pixel_ready_in), or immediately when the point is off-screen (no emission, 1 cycle/step).
  - Step rule, with e2=2*err (13b signed):
    - if e2 >= dy: err += dy, cx += sx.
    - if e2 <= dx: err += dx, cy += sy.
    - Both updates can happen in the same cycle.
  - Edge ends after the endpoint is consumed: go to SETUP for the next edge, or to DONE after e2.
  - Both endpoints are emitted on every edge, so shared vertices appear twice.
  - pixel_addr and pixel_valid_out hold stable while pixel_ready_in=0.
- DONE:
  - One cycle; tri_done_out=1, obj_done_out=accumulator.
  - Clear the accumulator and go to V0; ready_out=1 the next cycle.
- Latency: the third vertex is accepted at cycle N, SETUP runs at N+1, and the first pixel_valid_out is at N+2.
- Throughput: 1 pixel/cycle under full ready, plus 1 SETUP cycle per edge.
- Degenerate edge (identical endpoints): exactly one pixel emitted.
- Coordinates are 9-bit unsigned, 0..511; no negative wrap is possible.

Optional Feature:
- Macro: BACKFACE_CULL_EN.
- Defined:
  - An extra CULL state sits between V2 and the first SETUP (1 cycle).
  - area = (x1-x0)*(y2-y0) - (x2-x0)*(y1-y0), 21b signed.
  - area < 0: skip drawing and go to DONE (tri_done_out and obj_done_out pulse normally, zero pixels).
  - area >= 0: draw; first pixel arrives at N+3.
- Undefined: no CULL state; every triangle is drawn; first pixel arrives at N+2.

Test Plan:
- Vertices (0,0),(3,0),(0,3), ready always high:
  - 12 pixels in order 0,1,2,3 | 3,362,721,1080 | 1080,720,360,0.
  - tri_done_out pulses one cycle after the last pixel; ready_out=1 the following cycle.
- Same triangle, pixel_ready_in low for 5 cycles while addr=362 is presented:
  - addr holds at 362 with pixel_valid_out=1 throughout.
  - Identical 12-address sequence; no pixel lost or duplicated.
- Vertices (350,0),(370,0),(350,0):
  - e0 emits 350..359 (10 pixels), e1 emits 359..350 (10 pixels), e2 emits 350 (1 pixel); 21 pixels total.
  - No address with x >= 360 appears.
- Vertices all (5,5), obj_done_in=1 on the third vertex:
  - 3 pixels at addr 1805.
  - tri_done_out=1 and obj_done_out=1 in the same cycle.
  - ready_out=0 from the third accept until after DONE.
- Reset (rst_in=0) for one cycle mid e1:
  - Next cycle pixel_valid_out=0 and ready_out=0; then ready_out=1.
  - A fresh triangle draws correctly with no remnants.
- Cull, with BACKFACE_CULL_EN defined:
  - Order (0,0),(0,3),(3,0) has area -9: zero pixels, tri_done_out pulses.
  - Order (0,0),(3,0),(0,3) has area +9: 12 pixels as in the first scenario.
